// File: rtl/mem2d_frame_ctrl_if.sv
// Stream bundle for mem2d_frame_ctrl.
// Carries the input pixel stream (s_*) and the output pixel stream (m_*).
//   master : controller side (accepts s_*, produces m_*)
//   slave  : environment side (produces s_*, accepts m_*)
// Parameter D_W : pixel width.
interface mem2d_frame_ctrl_if #(
  parameter int D_W = 8
);
  logic           s_valid;
  logic [D_W-1:0] s_data;
  logic           s_ready;
  logic           m_valid;
  logic [D_W-1:0] m_data;
  logic           m_ready;
  logic           m_last;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/mem2d_frame_ctrl.sv
// Frame buffer controller in front of the mem2d 2-D memory.
// On start, fills one W x H frame from the s_* stream in raster order,
// then drains it back out on the m_* stream, pulsing done at the end.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a frame (sampled only in IDLE)
//   bus (master)      s_valid/s_data/s_ready input stream,
//                     m_valid/m_data/m_ready/m_last output stream
//   busy              high while filling or draining
//   done              one-cycle pulse after the final drain handshake
//   mem_addr_x/_y     memory address (counters, 0 when idle)
//   mem_data_in       write data (follows s_data)
//   mem_wr            write strobe (s_valid while filling)
//   mem_data_out      combinational read data from mem2d
//
// Build option: define MEM2D_TRANSPOSE_EN to drain in column-major order
// (y fast, x slow). Fill order is raster in both builds.
module mem2d_frame_ctrl #(
  parameter int W   = 64,
  parameter int H   = 32,
  parameter int X_W = 6,
  parameter int Y_W = 5,
  parameter int D_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  mem2d_frame_ctrl_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic [X_W-1:0]       mem_addr_x,
  output logic [Y_W-1:0]       mem_addr_y,
  output logic [D_W-1:0]       mem_data_in,
  output logic                 mem_wr,
  input  logic [D_W-1:0]       mem_data_out
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [X_W-1:0] X_MAX = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(H - 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_t         state;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           s_ready_r;
  logic           m_valid_r;
  logic           busy_r;
  logic           at_last;

  assign at_last = (x_cnt == X_MAX) && (y_cnt == Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_cnt     <= '0;
      y_cnt     <= '0;
      done      <= 1'b0;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            x_cnt     <= '0;
            y_cnt     <= '0;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        FILL: begin
          if (bus.s_valid) begin
            if (at_last) begin
              // Frame complete: restart counters for the drain pass.
              state     <= DRAIN;
              x_cnt     <= '0;
              y_cnt     <= '0;
              s_ready_r <= 1'b0;
              m_valid_r <= 1'b1;
            end else if (x_cnt == X_MAX) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + Y_ONE;
            end else begin
              x_cnt <= x_cnt + X_ONE;
            end
          end
        end
        DRAIN: begin
          if (bus.m_ready) begin
            // (W-1,H-1) is the final pixel in either drain order.
            if (at_last) begin
              state     <= IDLE;
              x_cnt     <= '0;
              y_cnt     <= '0;
              m_valid_r <= 1'b0;
              busy_r    <= 1'b0;
              done      <= 1'b1;
            end else begin
`ifdef MEM2D_TRANSPOSE_EN
              if (y_cnt == Y_MAX) begin
                y_cnt <= '0;
                x_cnt <= x_cnt + X_ONE;
              end else begin
                y_cnt <= y_cnt + Y_ONE;
              end
`else
              if (x_cnt == X_MAX) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + Y_ONE;
              end else begin
                x_cnt <= x_cnt + X_ONE;
              end
`endif
            end
          end
        end
        default: begin
          state     <= IDLE;
          x_cnt     <= '0;
          y_cnt     <= '0;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Counters are held at zero in IDLE, so they can drive the address directly.
  assign mem_addr_x  = x_cnt;
  assign mem_addr_y  = y_cnt;
  assign mem_data_in = bus.s_data;
  assign mem_wr      = s_ready_r & bus.s_valid;

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_data  = mem_data_out;
  assign bus.m_last  = m_valid_r & at_last;
  assign busy        = busy_r;

endmodule

// File: doc/mem2d_frame_ctrl.md
# mem2d_frame_ctrl

Frame buffer controller that sits directly upstream of the `mem2d` 2-D memory (64 x 32 x 8-bit) and owns all of its ports. On `start` it accepts one frame of pixels over a valid/ready stream and writes them in raster order. It then reads the frame back out of the memory onto a second valid/ready stream for the next processing stage.

## Interface
- `W`, default 64: frame width in pixels (x extent); legal range 2..2^X_W.
- `H`, default 32: frame height in lines (y extent); legal range 2..2^Y_W.
- `X_W`, default 6: x address width; must match `mem2d` `addr_x`.
- `Y_W`, default 5: y address width; must match `mem2d` `addr_y`.
- `D_W`, default 8: pixel width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `s_valid`  in  1  input pixel valid.
- `s_data`  in  D_W  input pixel.
- `s_ready`  out  1  controller accepts a pixel.
- `m_valid`  out  1  output pixel valid.
- `m_data`  out  D_W  output pixel; driven combinationally from `mem_data_out`.
- `m_ready`  in  1  downstream accepts a pixel.
- `m_last`  out  1  marks the final pixel of the frame.
- `busy`  out  1  high in FILL or DRAIN.
- `done`  out  1  one-cycle pulse at frame completion.
- `mem_addr_x`  out  X_W  to `mem2d.addr_x`.
- `mem_addr_y`  out  Y_W  to `mem2d.addr_y`.
- `mem_data_in`  out  D_W  to `mem2d.data_in`.
- `mem_wr`  out  1  to `mem2d.wr`.
- `mem_data_out`  in  D_W  from `mem2d.data_out`. Memory read is combinational; a write takes effect at the clock edge.

## Operation
- **FSM states:** IDLE, FILL, DRAIN. Moore decodes:
  - `s_ready` = (state == FILL)
  - `m_valid` = (state == DRAIN)
  - `busy` = (state != IDLE)
- **Counters:** `x_cnt` (X_W bits) and `y_cnt` (Y_W bits), both 0 in IDLE. They drive `mem_addr_x` and `mem_addr_y` in FILL and DRAIN. In IDLE the address outputs are 0.
- **IDLE → FILL:** when `start` = 1; counters are cleared.
  - `start` is ignored in FILL and DRAIN.
- **FILL:**
  - `mem_wr` = `s_valid` (combinational); `mem_data_in` = `s_data`.
  - On each accepted pixel, advance raster order: `x_cnt` +1. When `x_cnt` = W-1, it wraps to 0 and `y_cnt` +1.
  - Accepting pixel (W-1, H-1) clears both counters and moves the FSM to DRAIN.
- **DRAIN:**
  - `mem_wr` = 0; `m_data` = `mem_data_out`.
  - Counters advance only on `m_valid && m_ready`. With `m_ready` low, the address and `m_data` hold stable.
  - `m_last` = 1 while the counters point at the final drain pixel.
  - The handshake on the final pixel moves the FSM to IDLE and pulses `done` for one cycle.
- **Arithmetic:** counters never exceed W-1 / H-1; there is no modulo 2^N wrap beyond those bounds.
- **Reset (any state, including mid-frame):**
  - FSM goes to IDLE; counters and `done` go to 0.
  - Outputs after reset: `s_ready`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, `mem_wr`=0, `mem_addr_x`=0, `mem_addr_y`=0.
  - `mem_data_in` follows `s_data`; it is only meaningful when `mem_wr`=1.
  - Partial frame contents left in memory are don't-care.

## Timing
- `start` sampled high at edge N: `s_ready` is high from cycle N+1.
- Write of the last pixel at edge M: `m_valid` is high in cycle M+1, presenting pixel (0,0) with the new data already visible.
- Drain throughput is one pixel per cycle with `m_ready` held high. A full frame takes W·H cycles to fill and W·H cycles to drain, with no bubbles.
- Last drain handshake at edge K: `done`=1 and IDLE in cycle K+1. `start` high in that cycle is accepted, so a new FILL begins at K+2.
- `s_valid` low in FILL: no write, counters hold. No timeout.

## Configuration
- **`MEM2D_TRANSPOSE_EN` defined:** DRAIN reads column-major: `y_cnt` is the fast counter and `x_cnt` advances on `y_cnt` wrap. The output order is (0,0),(0,1)…(0,H-1),(1,0)… Final pixel and `m_last` remain at (W-1,H-1).
- **Not defined:** DRAIN uses the same row-major order as FILL.
- FILL order is identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0, `busy`=0. Assert `rst_n`=0 mid-DRAIN → IDLE in the same cycle, `m_valid`=0 without waiting for a clock.
- **Basic frame, W=4 H=3:** stream pixels 0x00..0x0B with `m_ready`=1 → `m_data` sequence 0x00..0x0B, `m_last` only on 0x0B, `done` one cycle after the 0x0B handshake.
- **Backpressure:** in DRAIN toggle `m_ready` 1,0,0,1 → `m_data` and address hold during the low cycles, no pixel duplicated or dropped.
- **Input gaps:** in FILL drive `s_valid` low every other cycle → `mem_wr` mirrors `s_valid`; FILL lasts 24 cycles for 12 pixels; DRAIN data is correct.
- **Transpose build, W=4 H=3, same input:** → order 0x00,0x04,0x08,0x01,0x05,0x09,…,0x0B, `m_last` on 0x0B.
- **Back-to-back frames:** `start` held high → second FILL begins two cycles after the first frame's last handshake. `start` pulsed during FILL is ignored.
